// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and drives the EX-stage stall request
// while a division is in flight.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; result and ready held at zero
// BYZERO | divisor was zero; next cycle presents result 0 with ready
// ON     | one shift-subtract iteration per cycle, cnt counts iterations
// END    | ready high, result held until start drops
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_req
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // {partial remainder (WIDTH+1 bits), quotient/dividend (WIDTH bits)}
    logic [2*WIDTH:0]     pr_q, pr_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sgn_q, sgn_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH:0]     pr_shift;
    logic [WIDTH:0]       rem_hi;
    logic [WIDTH:0]       rem_sub;
    logic [2*WIDTH:0]     pr_step;
    logic [WIDTH-1:0]     quo_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 last_iter;

    // Operand magnitudes; negation only applies to negative signed operands.
    always_comb begin
        abs_a = (signed_div && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        abs_b = (signed_div && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    end

    // One restoring step: shift left, subtract the divisor if it fits, and
    // shift the resulting quotient bit in at the bottom.
    always_comb begin
        pr_shift = {pr_q[2*WIDTH-1:0], 1'b0};
        rem_hi   = pr_shift[2*WIDTH:WIDTH];
        rem_sub  = rem_hi - {1'b0, b_q};
        if (rem_hi >= {1'b0, b_q}) begin
            pr_step = {rem_sub, pr_shift[WIDTH-1:1], 1'b1};
        end else begin
            pr_step = {rem_hi, pr_shift[WIDTH-1:1], 1'b0};
        end
        quo_raw   = pr_step[WIDTH-1:0];
        rem_raw   = pr_step[2*WIDTH-1:WIDTH];
        quo_fix   = (sgn_q && (sa_q ^ sb_q)) ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix   = (sgn_q && sa_q) ? (~rem_raw + 1'b1) : rem_raw;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start && !annul) begin
                    if (divisor != '0) begin
                        pr_d    = {{(WIDTH+1){1'b0}}, abs_a};
                        b_d     = abs_b;
                        sgn_d   = signed_div;
                        sa_d    = dividend[WIDTH-1];
                        sb_d    = divisor[WIDTH-1];
                        cnt_d   = '0;
                        state_d = S_ON;
                    end else begin
                        state_d = S_BYZERO;
                    end
                end
            end
            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end
            S_ON: begin
                if (annul) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    pr_d  = pr_step;
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (!start) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pr_q     <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pr_q     <= pr_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result    = result_q;
    assign ready     = ready_q;
    assign stall_req = start & ~annul & (state_q != S_END) & ~rst;

endmodule
